or_bitwise: RTL and testbench

//   Registered bitwise-OR unit of the 32-bit ALU datapath.
//   - Produces o = i_1 | i_2 one clock after a valid input, with a valid strobe and zero/all-ones flags.
//   - The ALU result mux selects this output when the opcode is OR.

---
 rtl/alu_pkg.sv | 17 +
 rtl/or_bitwise_core.sv | 24 ++
 rtl/or_bitwise.sv | 59 +++++
 tb/tb_or_bitwise.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the 32-bit ALU datapath units.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SLL = 4'h5,
        OP_SRL = 4'h6,
        OP_SRA = 4'h7
    } alu_op_e;

endpackage

// File: rtl/or_bitwise_core.sv
// Combinational bitwise OR with zero / all-ones reduction flags.
module or_bitwise_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    output logic [WIDTH-1:0] o,
    output logic             o_zero,
    output logic             o_ones
);

    logic [WIDTH-1:0] w_or;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign w_or[g] = i_1[g] | i_2[g];
    end

    assign o      = w_or;
    assign o_zero = ~|w_or;
    assign o_ones = &w_or;

endmodule

// File: rtl/or_bitwise.sv
// Registered bitwise-OR ALU unit: one-cycle latency result plus valid and flags.
module or_bitwise
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             o_zero,
    output logic             o_ones
);

    logic [WIDTH-1:0] w_or;
    logic             w_zero;
    logic             w_ones;

    logic [WIDTH-1:0] r_o;
    logic             r_valid;
    logic             r_zero;
    logic             r_ones;

    or_bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_1    (i_1),
        .i_2    (i_2),
        .o      (w_or),
        .o_zero (w_zero),
        .o_ones (w_ones)
    );

    // Data registers load only on a valid pair, so idle-cycle X on operands never reaches o.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_o     <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
            r_ones  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_o    <= w_or;
                r_zero <= w_zero;
                r_ones <= w_ones;
            end
        end
    end

    assign o       = r_o;
    assign o_valid = r_valid;
    assign o_zero  = r_zero;
    assign o_ones  = r_ones;

endmodule

// File: tb/tb_or_bitwise.sv
// Self-checking bench for or_bitwise: directed cases plus randomized traffic against a reference model.
module tb_or_bitwise;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic         o_valid;
    logic         o_zero;
    logic         o_ones;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state: what the outputs must show after the most recent edge
    logic [W-1:0] m_o;
    logic         m_v;
    logic         m_z;
    logic         m_1;

    or_bitwise #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (vld),
        .i_1     (a),
        .i_2     (b),
        .o       (o),
        .o_valid (o_valid),
        .o_zero  (o_zero),
        .o_ones  (o_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, then compare all outputs.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] res;
        rst_n = r;
        vld   = v;
        a     = x;
        b     = y;
        @(posedge clk);
        if (!r) begin
            m_o = '0; m_v = 1'b0; m_z = 1'b1; m_1 = 1'b0;
        end else if (v) begin
            res = x | y;
            m_o = res;
            m_v = 1'b1;
            m_z = (res == 0);
            m_1 = (res == {W{1'b1}});
        end else begin
            m_v = 1'b0;
        end
        #1;
        chk("o",       o,                  m_o);
        chk("o_valid", {{(W-1){1'b0}}, o_valid}, {{(W-1){1'b0}}, m_v});
        chk("o_zero",  {{(W-1){1'b0}}, o_zero},  {{(W-1){1'b0}}, m_z});
        chk("o_ones",  {{(W-1){1'b0}}, o_ones},  {{(W-1){1'b0}}, m_1});
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        chk(tag, {{(W-1){1'b0}}, got}, {{(W-1){1'b0}}, exp});
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] held;
        rst_n = 1'b0; vld = 1'b0; a = '0; b = '0;
        m_o = '0; m_v = 1'b0; m_z = 1'b1; m_1 = 1'b0;
        @(negedge clk);

        // 1: reset with valid asserted
        cycle(1'b0, 1'b1, 32'h1234_5678, 32'h0F0F_0000);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("rst_o", o, 32'h0);
        chk_bit("rst_valid", o_valid, 1'b0);
        chk_bit("rst_zero", o_zero, 1'b1);
        chk_bit("rst_ones", o_ones, 1'b0);

        // 2: basic OR, one-cycle latency
        cycle(1'b1, 1'b1, 32'h0000_129F, 32'h0000_0BD2);
        chk("t2_o", o, 32'h0000_1BDF);
        chk_bit("t2_valid", o_valid, 1'b1);
        chk_bit("t2_zero", o_zero, 1'b0);
        chk_bit("t2_ones", o_ones, 1'b0);

        // 3: ones dominance
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hA849_2525);
        chk("t3a_o", o, 32'hFFFF_FFFF);
        chk_bit("t3a_ones", o_ones, 1'b1);
        cycle(1'b1, 1'b1, 32'hE800_1900, 32'hFFFF_FFFF);
        chk("t3b_o", o, 32'hFFFF_FFFF);
        chk_bit("t3b_ones", o_ones, 1'b1);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
        chk("t3c_o", o, 32'hFFFF_FFFF);
        chk_bit("t3c_ones", o_ones, 1'b1);
        chk_bit("t3c_zero", o_zero, 1'b0);

        // 4: mixed bits back-to-back
        cycle(1'b1, 1'b1, 32'hFF8F_E94B, 32'hFFFC_4A3F);
        chk("t4a_o", o, 32'hFFFF_EB7F);
        chk_bit("t4a_valid", o_valid, 1'b1);
        chk_bit("t4a_ones", o_ones, 1'b0);
        cycle(1'b1, 1'b1, 32'hFFA5_21FF, 32'h8000_0007);
        chk("t4b_o", o, 32'hFFA5_21FF);
        chk_bit("t4b_valid", o_valid, 1'b1);

        // 5: zero result, then hold with idle cycles (including X operands)
        cycle(1'b1, 1'b1, 32'h0, 32'h0);
        chk("t5_o", o, 32'h0);
        chk_bit("t5_zero", o_zero, 1'b1);
        chk_bit("t5_ones", o_ones, 1'b0);
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF);
        chk("t5_hold_o", o, 32'h0);
        chk_bit("t5_hold_valid", o_valid, 1'b0);
        chk_bit("t5_hold_zero", o_zero, 1'b1);
        cycle(1'b1, 1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        chk("t5_x_o", o, 32'h0);
        chk_bit("t5_x_zero", o_zero, 1'b1);

        // 6: reset coincident with a valid pair, then recovery
        cycle(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F);
        chk("t6_pre_o", o, 32'h0000_00FF);
        cycle(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222);
        chk("t6_rst_o", o, 32'h0);
        chk_bit("t6_rst_valid", o_valid, 1'b0);
        cycle(1'b1, 1'b1, 32'h0101_0000, 32'h0000_1010);
        chk("t6_rec_o", o, 32'h0101_1010);
        chk_bit("t6_rec_valid", o_valid, 1'b1);

        // randomized traffic, biased toward flag corners and occasional resets
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: begin x = '0; y = '0; end
                1: x = '1;
                2: y = ~x;
                3: begin x = x & $urandom; y = y & $urandom; end
                default: ;
            endcase
            cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), x, y);
        end

        // final idle hold check after random traffic
        cycle(1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000);
        held = o;
        chk("end_o", held, 32'h8000_0001);
        cycle(1'b1, 1'b0, 32'h7FFF_FFFE, 32'h7FFF_FFFE);
        chk("end_hold_o", o, 32'h8000_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
